qdma_stm_c2h_gen: RTL
=====================

Name: qdma_stm_c2h_gen

Overview:
- Programmable C2H stream traffic generator. It is the transmit-only counterpart of the H2C-to-C2H loopback path.
- On a start command it emits N packets of a fixed byte length and a deterministic pattern on the C2H payload stream toward QDMA.
- Each packet is followed by one completion entry on the C2H completion stream.
- Sits beside the loopback in the streaming example design. Used for C2H-only throughput tests and driver bring-up.

Parameters:
MAX_DATA_WIDTH, 512, payload bus width in bits; BPB = MAX_DATA_WIDTH/8 bytes per beat
QID_BITS, 11, queue id width
LEN_BITS, 16, packet length field width (bytes)
CMP_WIDTH, 128, completion entry width
TCQ, 0, simulation clock-to-q delay on registered assignments

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
cfg_start  in  1  one-cycle start pulse; config latched on it
cfg_qid  in  QID_BITS  target queue
cfg_pkt_len  in  LEN_BITS  packet length in bytes
cfg_num_pkts  in  16  packet count
cfg_busy  out  1  high from accepted start until done
cfg_done  out  1  one-cycle pulse at end of run
stat_pkt_cnt  out  16  completions accepted this run
out_axis_pld_tdata  out  MAX_DATA_WIDTH  payload data
out_axis_pld_len  out  LEN_BITS  packet length, constant over packet
out_axis_pld_qid  out  QID_BITS  queue id, constant over packet
out_axis_pld_has_cmpt  out  1  always 1 while valid
out_axis_pld_mty  out  $clog2(BPB)  empty bytes on last beat
out_axis_pld_tlast  out  1  last beat of packet
out_axis_pld_tvalid  out  1  payload valid
out_axis_pld_tready  in  1  payload ready
out_axis_cmp_data  out  CMP_WIDTH  completion entry
out_axis_cmp_tlast  out  1  always 1 while cmp valid
out_axis_cmp_tvalid  out  1  completion valid
out_axis_cmp_tready  in  1  completion ready

Behaviour:
- Reset (rst_n=0 sampled at clk): all outputs 0, FSM to IDLE, counters 0. Reset mid-packet aborts immediately with no further beats. Stall cost and retry are the consumer's concern.
- FSM states: IDLE, PLD, CMP, DONE.
- IDLE:
  - cfg_start with len!=0 and num!=0: latch qid/len/num, clear stat_pkt_cnt and pkt_seq, go to PLD.
  - cfg_start with len==0 or num==0: go to DONE, emit no traffic.
  - cfg_start is ignored outside IDLE.
- Latency: start at edge N gives pld_tvalid=1 after edge N+1.
- PLD:
  - Beats per packet = ceil(len/BPB), counted by beat_idx.
  - Byte i of beat b = (pkt_seq[7:0] + b*BPB + i) mod 256.
  - tlast=1 on the final beat only.
  - mty = beats*BPB - len on the last beat, 0 otherwise.
  - Transfer occurs on tvalid&tready. Data, ctrl and mty hold stable while tvalid=1 and tready=0. tvalid never drops without a transfer.
  - Accepted last beat goes to CMP; no payload beat is issued until the completion is accepted.
- CMP:
  - cmp_tvalid=1 with cmp_data[15:0]=len, [31:16]=pkt_seq, [32+QID_BITS-1:32]=qid, remaining bits 0.
  - On tready: stat_pkt_cnt+1 and pkt_seq+1. Go to PLD if more packets remain, else DONE.
- DONE: cfg_done=1 for exactly one cycle, then IDLE. cfg_busy=1 in PLD/CMP/DONE.
- Width rules:
  - Beat count is computed at LEN_BITS+1 width, with no overflow for len=2^LEN_BITS-1.
  - pkt_seq and stat_pkt_cnt wrap at 2^16.
  - Payload and completion valid are never high in the same cycle.

Decomposition:
- Shared package (qdma_stm_defines): completion field offsets, the c2h generator state enum, and the BPB/mty-width localparams.
- One natural sub-module, qdma_stm_c2h_gen_pat: combinational pattern/mty generator taking (pkt_seq, beat_idx, len, is_last). Keeps the FSM/handshake core small.

Test Plan:
- len=64, num=1, tready=1: one beat, tlast=1, mty=0, bytes 0x00..0x3F. Then one cmp with len=64, seq=0. cfg_done pulses once; stat=1.
- len=65, num=1: two beats. Beat 1 starts at byte 0x40; mty=63 on beat 1. cmp len=65.
- len=130, num=3, qid=5: 3 beats per packet, last mty=62. cmp seq=0,1,2 with qid field=5. Packet 2 byte0=0x02. stat=3.
- Random tready on both streams at 30% duty, len=200, num=4: all signals stable while stalled, no lost or duplicate beats, cmp never overlaps payload.
- cfg_num_pkts=0, then separately cfg_pkt_len=0: no valid asserted; cfg_done one cycle after the DONE transition. A second cfg_start while busy is ignored.
- rst_n=0 mid-beat 2 of a 4-beat packet: next cycle all valids=0 and busy=0. A new start runs from seq=0.

Source files
------------

// File: rtl/qdma_stm_defines.sv
// Shared definitions for the C2H stream generator: defaults, completion
// entry layout, FSM state encoding and beat-geometry helpers.
package qdma_stm_defines;

  localparam int C2H_BPB        = 64;
  localparam int C2H_DATA_WIDTH = C2H_BPB * 8;
  localparam int C2H_QID_BITS   = 11;
  localparam int C2H_LEN_BITS   = 16;
  localparam int C2H_CMP_WIDTH  = 128;

  localparam int CMP_LEN_LSB = 0;
  localparam int CMP_SEQ_LSB = 16;
  localparam int CMP_SEQ_W   = 16;
  localparam int CMP_QID_LSB = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLD  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } c2h_gen_state_e;

  function automatic int c2h_bpb(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int c2h_mty_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/qdma_stm_c2h_gen_if.sv
// C2H payload and completion stream bundle between the generator and QDMA.
interface qdma_stm_c2h_gen_if
  import qdma_stm_defines::*;
#(
  parameter int MAX_DATA_WIDTH = C2H_DATA_WIDTH,
  parameter int QID_BITS       = C2H_QID_BITS,
  parameter int LEN_BITS       = C2H_LEN_BITS,
  parameter int CMP_WIDTH      = C2H_CMP_WIDTH
);
  localparam int MTY_W = c2h_mty_w(MAX_DATA_WIDTH);

  logic [MAX_DATA_WIDTH-1:0] pld_tdata;
  logic [LEN_BITS-1:0]       pld_len;
  logic [QID_BITS-1:0]       pld_qid;
  logic                      pld_has_cmpt;
  logic [MTY_W-1:0]          pld_mty;
  logic                      pld_tlast;
  logic                      pld_tvalid;
  logic                      pld_tready;
  logic [CMP_WIDTH-1:0]      cmp_data;
  logic                      cmp_tlast;
  logic                      cmp_tvalid;
  logic                      cmp_tready;

  modport master (
    output pld_tdata, pld_len, pld_qid, pld_has_cmpt, pld_mty, pld_tlast, pld_tvalid,
    output cmp_data, cmp_tlast, cmp_tvalid,
    input  pld_tready, cmp_tready
  );

  modport slave (
    input  pld_tdata, pld_len, pld_qid, pld_has_cmpt, pld_mty, pld_tlast, pld_tvalid,
    input  cmp_data, cmp_tlast, cmp_tvalid,
    output pld_tready, cmp_tready
  );

endinterface

// File: rtl/qdma_stm_c2h_gen_pat.sv
// Combinational beat pattern and empty-byte generator: byte i of beat b is
// (pkt_seq + b*BPB + i) mod 256; mty is nonzero only on the last beat.
module qdma_stm_c2h_gen_pat
  import qdma_stm_defines::*;
#(
  parameter int MAX_DATA_WIDTH = C2H_DATA_WIDTH,
  parameter int LEN_BITS       = C2H_LEN_BITS
) (
  input  logic [15:0]                          pkt_seq,
  input  logic [LEN_BITS:0]                    beat_idx,
  input  logic [LEN_BITS-1:0]                  len,
  input  logic                                 is_last,
  output logic [MAX_DATA_WIDTH-1:0]            data,
  output logic [c2h_mty_w(MAX_DATA_WIDTH)-1:0] mty
);
  localparam int BPB   = c2h_bpb(MAX_DATA_WIDTH);
  localparam int MTY_W = c2h_mty_w(MAX_DATA_WIDTH);

  logic [7:0] base_s;

  assign base_s = 8'(pkt_seq) + 8'(beat_idx * BPB);

  // Incrementing byte ramp starting at this beat's base value
  always_comb begin
    data = '0;
    for (int i = 0; i < BPB; i++) begin
      data[i*8 +: 8] = base_s + 8'(i);
    end
  end

  // Empty bytes on the last beat equal (-len) mod BPB
  always_comb begin
    if (is_last) begin
      mty = MTY_W'(LEN_BITS'(0) - len);
    end else begin
      mty = '0;
    end
  end

endmodule

// File: rtl/qdma_stm_c2h_gen.sv
// C2H stream traffic generator: on a start command emits N fixed-length
// patterned packets, each followed by one completion entry.
module qdma_stm_c2h_gen
  import qdma_stm_defines::*;
#(
  parameter int MAX_DATA_WIDTH = C2H_DATA_WIDTH,
  parameter int QID_BITS       = C2H_QID_BITS,
  parameter int LEN_BITS       = C2H_LEN_BITS,
  parameter int CMP_WIDTH      = C2H_CMP_WIDTH,
  parameter int TCQ            = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic [QID_BITS-1:0] cfg_qid,
  input  logic [LEN_BITS-1:0] cfg_pkt_len,
  input  logic [15:0]         cfg_num_pkts,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic [15:0]         stat_pkt_cnt,
  qdma_stm_c2h_gen_if.master  out_axis
);
  localparam int BPB   = c2h_bpb(MAX_DATA_WIDTH);
  localparam int MTY_W = c2h_mty_w(MAX_DATA_WIDTH);

  // TCQ only shapes behavioural models; a negative value is meaningless
  if (TCQ < 0) begin : g_tcq_invalid
  end

  c2h_gen_state_e            state_r, state_s;
  logic [QID_BITS-1:0]       qid_r;
  logic [LEN_BITS-1:0]       len_r;
  logic [15:0]               pkts_left_r, pkt_seq_r, stat_cnt_r;
  logic [LEN_BITS:0]         beat_idx_r, beats_s;
  logic [MAX_DATA_WIDTH-1:0] pld_data_r, pat_data_s;
  logic [MTY_W-1:0]          pld_mty_r, pat_mty_s;
  logic                      pld_last_r, pld_valid_r;
  logic [CMP_WIDTH-1:0]      cmp_data_r, cmp_entry_s;
  logic                      cmp_valid_r, busy_r, done_r;
  logic                      run_ok_s, start_ok_s, is_last_s;
  logic                      pld_fire_s, pld_load_s, cmp_fire_s, cmp_load_s;

  assign run_ok_s   = (cfg_pkt_len != LEN_BITS'(0)) && (cfg_num_pkts != 16'd0);
  assign start_ok_s = (state_r == IDLE) && cfg_start && run_ok_s;
  // Extra top bit keeps the round-up from overflowing at maximum length
  assign beats_s    = ({1'b0, len_r} + (LEN_BITS+1)'(BPB - 1)) >> MTY_W;
  assign is_last_s  = ((beat_idx_r + (LEN_BITS+1)'(1)) == beats_s);
  assign pld_fire_s = pld_valid_r && out_axis.pld_tready;
  assign pld_load_s = (state_r == PLD) && (!pld_valid_r || (out_axis.pld_tready && !pld_last_r));
  assign cmp_fire_s = cmp_valid_r && out_axis.cmp_tready;
  assign cmp_load_s = (state_r == CMP) && !cmp_valid_r;

  qdma_stm_c2h_gen_pat #(
    .MAX_DATA_WIDTH (MAX_DATA_WIDTH),
    .LEN_BITS       (LEN_BITS)
  ) u_pat (
    .pkt_seq  (pkt_seq_r),
    .beat_idx (beat_idx_r),
    .len      (len_r),
    .is_last  (is_last_s),
    .data     (pat_data_s),
    .mty      (pat_mty_s)
  );

  // Completion entry layout: length, sequence, queue id, zero elsewhere
  always_comb begin
    cmp_entry_s = '0;
    cmp_entry_s[CMP_LEN_LSB +: LEN_BITS]  = len_r;
    cmp_entry_s[CMP_SEQ_LSB +: CMP_SEQ_W] = pkt_seq_r;
    cmp_entry_s[CMP_QID_LSB +: QID_BITS]  = qid_r;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cfg_start) begin
          state_s = run_ok_s ? PLD : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      PLD: begin
        if (pld_fire_s && pld_last_r) begin
          state_s = CMP;
        end else begin
          state_s = PLD;
        end
      end
      CMP: begin
        if (cmp_fire_s) begin
          state_s = (pkts_left_r == 16'd1) ? DONE : PLD;
        end else begin
          state_s = CMP;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Run config, counters and registered stream outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qid_r       <= '0;
      len_r       <= '0;
      pkts_left_r <= 16'd0;
      pkt_seq_r   <= 16'd0;
      stat_cnt_r  <= 16'd0;
      beat_idx_r  <= '0;
      pld_data_r  <= '0;
      pld_mty_r   <= '0;
      pld_last_r  <= 1'b0;
      pld_valid_r <= 1'b0;
      cmp_data_r  <= '0;
      cmp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (start_ok_s) begin
        qid_r       <= cfg_qid;
        len_r       <= cfg_pkt_len;
        pkts_left_r <= cfg_num_pkts;
        pkt_seq_r   <= 16'd0;
        stat_cnt_r  <= 16'd0;
        beat_idx_r  <= '0;
      end
      if (pld_load_s) begin
        pld_data_r  <= pat_data_s;
        pld_mty_r   <= pat_mty_s;
        pld_last_r  <= is_last_s;
        pld_valid_r <= 1'b1;
        beat_idx_r  <= beat_idx_r + (LEN_BITS+1)'(1);
      end else if (pld_fire_s) begin
        // Only the last beat fires without a reload behind it
        pld_valid_r <= 1'b0;
        pld_last_r  <= 1'b0;
        beat_idx_r  <= '0;
      end
      if (cmp_load_s) begin
        cmp_data_r  <= cmp_entry_s;
        cmp_valid_r <= 1'b1;
      end else if (cmp_fire_s) begin
        cmp_valid_r <= 1'b0;
        stat_cnt_r  <= stat_cnt_r + 16'd1;
        pkt_seq_r   <= pkt_seq_r + 16'd1;
        pkts_left_r <= pkts_left_r - 16'd1;
      end
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == DONE);
    end
  end

  assign cfg_busy              = busy_r;
  assign cfg_done              = done_r;
  assign stat_pkt_cnt          = stat_cnt_r;
  assign out_axis.pld_tdata    = pld_data_r;
  assign out_axis.pld_len      = len_r;
  assign out_axis.pld_qid      = qid_r;
  assign out_axis.pld_has_cmpt = pld_valid_r;
  assign out_axis.pld_mty      = pld_mty_r;
  assign out_axis.pld_tlast    = pld_last_r;
  assign out_axis.pld_tvalid   = pld_valid_r;
  assign out_axis.cmp_data     = cmp_data_r;
  assign out_axis.cmp_tlast    = cmp_valid_r;
  assign out_axis.cmp_tvalid   = cmp_valid_r;

endmodule
